// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline stage: a 2-entry skid buffer (SKID=1) that registers in_ready,
// or a 1-entry plain pipeline register (SKID=0) whose in_ready follows out_ready.
module pipe_skid_reg #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       SKID      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             stall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;

  // Skid mode breaks the out_ready -> in_ready path; plain mode trades that for one fewer entry.
  generate
    if (SKID != 0) begin : g_rdy_skid
      assign in_ready = !flush && !stall && (state_q != TWO);
    end else begin : g_rdy_plain
      assign in_ready = !flush && !stall && ((state_q == EMPTY) || out_ready);
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !stall && !flush;

  // NOTE: every variable gets a hold default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else if (!stall) begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire && !in_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: data registers are reset too, because out_data must show RESET_VAL after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end

  generate
    if (SKID != 0) begin : g_skid_reg
      always_ff @(posedge clk) begin
        if (reset) skid_q <= RESET_VAL;
        else       skid_q <= skid_d;
      end
    end else begin : g_no_skid
      assign skid_q = RESET_VAL;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: a skid instance checked through a data scoreboard,
// plus a plain-register instance checked for its ready behaviour.
module tb_pipe_skid_reg;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush, stall, in_valid, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        p_in_valid, p_out_ready;
  logic [31:0] p_in_data;
  logic        p_in_ready, p_out_valid;
  logic [31:0] p_out_data;
  logic [1:0]  p_occupancy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(RV), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(32), .RESET_VAL(32'h0), .SKID(0)) dut_plain (
    .clk(clk), .reset(reset), .flush(1'b0), .stall(1'b0),
    .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
    .occupancy(p_occupancy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on the skid instance: drive at negedge, check just after, let posedge commit.
  task automatic step(input string tag, input logic iv, input logic [31:0] id,
                      input logic ordy, input logic st, input logic fl,
                      input logic exp_rdy, input logic [1:0] exp_occ);
    logic [31:0] exp_data;
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    check({tag, ".occupancy"}, 32'(occupancy), 32'(exp_occ));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_occ != 2'd0));
    if (fl) begin
      sb_q.delete();
    end else if (out_valid && ordy && !st) begin
      check({tag, ".sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_data = sb_q.pop_front();
        check({tag, ".out_data"}, out_data, exp_data);
      end
    end
    if (iv && exp_rdy) sb_q.push_back(id);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0;
    p_in_valid = 1'b0; p_out_ready = 1'b0; p_in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.occupancy", 32'(occupancy), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", out_data, RV);
    reset = 1'b0;
    #1;
    check("rst.in_ready_after", 32'(in_ready), 32'd1);

    // Streaming: one payload per cycle, occupancy stays at 1.
    step("str0", 1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    step("str1", 1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    step("str2", 1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    step("str3", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1);

    // Backpressure: fill both entries, a third offer must be refused, then drain in order.
    step("bp0", 1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    step("bp1", 1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    step("bp2", 1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2);
    step("bp3", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    step("bp4", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    step("bp5", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);

    // Stall in TWO: nothing moves for three cycles, then 0x5 and 0x6 leave in order.
    step("st0", 1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    step("st1", 1'b1, 32'h6, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int i = 0; i < 3; i++)
      step("st_hold", 1'b1, 32'h99, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
    step("st2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2);
    step("st3", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1);

    // Flush beats stall and the offered 0x77; the empty stage first shows the last value.
    step("fl0", 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    check("fl0.hold_last", out_data, 32'h6);
    step("fl1", 1'b1, 32'h77, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1);
    step("fl2", 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    check("fl2.out_data", out_data, RV);

    // Reset while holding two entries; the offer in the reset cycle is ignored.
    step("rt0", 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0);
    step("rt1", 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_data = 32'h3; out_ready = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("rt.occupancy", 32'(occupancy), 32'd0);
    check("rt.out_valid", 32'(out_valid), 32'd0);
    check("rt.out_data", out_data, RV);
    reset = 1'b0; in_valid = 1'b0;
    #1;
    check("rt.in_ready", 32'(in_ready), 32'd1);
    step("rt2", 1'b1, 32'h55, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0);
    step("rt3", 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 2'd1);
    check("rt3.sb_drained", 32'(sb_q.size()), 32'd0);

    // Plain register: in_ready follows out_ready while full; replace is one-for-one.
    @(negedge clk);
    p_in_valid = 1'b1; p_in_data = 32'hA1; p_out_ready = 1'b0;
    #1;
    check("pl0.in_ready", 32'(p_in_ready), 32'd1);
    @(negedge clk);
    p_in_data = 32'hA2;
    #1;
    check("pl1.in_ready", 32'(p_in_ready), 32'd0);
    check("pl1.occupancy", 32'(p_occupancy), 32'd1);
    check("pl1.out_data", p_out_data, 32'hA1);
    @(negedge clk);
    p_out_ready = 1'b1;
    #1;
    check("pl2.in_ready", 32'(p_in_ready), 32'd1);
    check("pl2.out_data", p_out_data, 32'hA1);
    @(negedge clk);
    p_in_valid = 1'b0; p_out_ready = 1'b0;
    #1;
    check("pl3.occupancy", 32'(p_occupancy), 32'd1);
    check("pl3.out_data", p_out_data, 32'hA2);
    @(negedge clk);
    p_out_ready = 1'b1;
    @(negedge clk);
    p_out_ready = 1'b0;
    #1;
    check("pl4.occupancy", 32'(p_occupancy), 32'd0);
    check("pl4.out_valid", 32'(p_out_valid), 32'd0);
    check("pl4.out_data", p_out_data, 32'hA2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; clock port clk, reset port reset, both sampled on the rising edge of clk.
REQ-002 Parameter WIDTH, default 32, SHALL give the payload width in bits; legal range is 1..1024.
REQ-003 Parameter RESET_VAL, default 0, SHALL give the payload value loaded on reset or flush; it is WIDTH bits wide.
REQ-004 Parameter SKID, default 1, SHALL select the buffering mode: 1 gives a 2-entry skid buffer, 0 gives a 1-entry plain pipeline register.
REQ-005 Port list, clock and reset first (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all held entries
- stall  in  1  freeze the stage
- in_valid  in  1  upstream holds a payload
- in_ready  out  1  stage accepts a payload this cycle
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  stage presents a payload
- out_ready  in  1  downstream accepts a payload
- out_data  out  WIDTH  presented payload
- occupancy  out  2  number of held entries, 0..2

Function
REQ-006 The stage SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready & !stall & !flush.
REQ-007 The stage SHALL keep a main register, which drives out_data, and, only when SKID=1, a skid register.
REQ-008 The state machine SHALL have the states EMPTY, ONE and TWO; TWO SHALL exist only when SKID=1; occupancy SHALL encode these as 0, 1 and 2.
REQ-009 out_valid SHALL be 1 exactly when the state is not EMPTY.
REQ-010 With SKID=1, in_ready SHALL equal !flush & !stall & (state != TWO), so it has no combinational path from out_ready.
REQ-011 With SKID=0, in_ready SHALL equal !flush & !stall & (state==EMPTY | out_ready).
REQ-012 State transitions SHALL be, in priority order:
- reset or flush: go to EMPTY and load both registers with RESET_VAL.
- stall: hold the state and both registers.
- EMPTY with in_fire: go to ONE, main <= in_data.
- ONE with in_fire & out_fire: stay in ONE, main <= in_data.
- ONE with in_fire & !out_fire: with SKID=1 go to TWO and skid <= in_data; with SKID=0 this case is unreachable.
- ONE with out_fire & !in_fire: go to EMPTY, main holds its value.
- TWO with out_fire: go to ONE, main <= skid.
- all other cases: hold.
REQ-013 Latency SHALL be one cycle: a payload accepted in cycle N SHALL appear on out_data with out_valid=1 in cycle N+1.
REQ-014 Order SHALL be preserved: payloads SHALL leave in the order they were accepted, with no loss or duplication except by flush.
REQ-015 Flush SHALL take priority over stall and over any input in the same cycle; that input SHALL be dropped because in_ready=0.
REQ-016 out_data in EMPTY SHALL hold the last presented value, or RESET_VAL after reset or flush.
REQ-017 With SKID=1 and both sides continuously ready, throughput SHALL be one payload per cycle.
REQ-018 Outputs SHALL depend only on registered state and on the inputs named in REQ-010 and REQ-011.

Reset
REQ-019 While reset=1, the stage SHALL force on the next edge: state EMPTY, occupancy 0, out_valid 0, out_data = RESET_VAL, skid = RESET_VAL.
REQ-020 Reset asserted mid-transfer, in ONE or TWO, SHALL discard all entries; any in_fire in that cycle SHALL be ignored.
REQ-021 After reset deasserts, in_ready SHALL be 1 in the same cycle, provided flush=0 and stall=0.

Verification
REQ-022 Streaming test: SKID=1, WIDTH=32, out_ready=1, inputs 0x11, 0x22, 0x33 on consecutive cycles -> out_data 0x11, 0x22, 0x33 one cycle later each, occupancy stays 1.
REQ-023 Backpressure test: SKID=1, input 0xA then 0xB, out_ready=0 -> occupancy 2 and in_ready=0; then out_ready=1 -> out_data 0xA then 0xB, occupancy returns 0.
REQ-024 Stall test: state TWO holding 0x5 and 0x6, stall=1 for 3 cycles with out_ready=1 -> no out_fire, in_ready=0, occupancy stays 2; then stall=0 -> 0x5 then 0x6.
REQ-025 Flush-priority test: state ONE, flush=1 and stall=1 together with in_valid=1, in_data=0x77 -> next cycle EMPTY, out_data=RESET_VAL, and 0x77 never appears.
REQ-026 Plain-register test: SKID=0, out_ready=0 in ONE -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> in_ready=1 and a one-for-one replace.
REQ-027 Reset test: reset asserted in state TWO -> occupancy 0 and out_valid 0 on the next edge, and RESET_VAL=0xDEAD_BEEF appears on out_data.
